shift_seq_unit: RTL and testbench

//  Multi-cycle shift/rotate unit for the pipelined core's EX stage. Counterpart of the single-cycle

---
 rtl/shift_seq_unit_pkg.sv | 24 ++
 rtl/shift_seq_unit_if.sv | 26 ++
 rtl/shift_seq_unit_stage.sv | 29 ++
 rtl/shift_seq_unit.sv | 72 +++++++
 tb/tb_shift_seq_unit.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/shift_seq_unit_pkg.sv
// shift_seq_unit_pkg: shared types and defaults for the multi-cycle shift/rotate unit
//   DEF_XLEN / DEF_SHAMT_W : default operand width and shift-amount width
//   shift_op_e             : operation encoding (values above OP_ROR are invalid)
//   shift_state_e          : control FSM states
//   op_known()             : true for encodings that name a real operation
package shift_seq_unit_pkg;
    localparam int DEF_XLEN = 32;
    localparam int DEF_SHAMT_W = $clog2(DEF_XLEN);
    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100
    } shift_op_e;
    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } shift_state_e;
    function automatic logic op_known(logic [2:0] op);
        return op <= OP_ROR;
    endfunction
endpackage

// File: rtl/shift_seq_unit_if.sv
// shift_seq_unit_if: request/response handshake bundle of the shift unit
//   i_valid/o_ready : request handshake, with i_op, i_a (operand), i_b (shift amount source)
//   i_kill          : pipeline flush
//   o_valid/i_ready : result handshake, with o_data
//   master          : requester/consumer side; slave: the shift unit
interface shift_seq_unit_if import shift_seq_unit_pkg::*; #(
    parameter int XLEN = DEF_XLEN
) ();
    logic            i_valid;
    logic            o_ready;
    logic [2:0]      i_op;
    logic [XLEN-1:0] i_a;
    logic [XLEN-1:0] i_b;
    logic            i_kill;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_data;
    modport master (
        output i_valid, i_op, i_a, i_b, i_kill, i_ready,
        input  o_ready, o_valid, o_data
    );
    modport slave (
        input  i_valid, i_op, i_a, i_b, i_kill, i_ready,
        output o_ready, o_valid, o_data
    );
endinterface

// File: rtl/shift_seq_unit_stage.sv
// shift_stage: one combinational shift/rotate step by distance 2**k
//   data   : value to shift
//   k      : stage index; distance is 2**k
//   op     : operation (shift_op_e encoding); unknown encodings give 0
//   sign   : fill bit for SRA, the operand's original MSB
//   result : shifted/rotated value
module shift_stage import shift_seq_unit_pkg::*; #(
    parameter int XLEN = DEF_XLEN,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic [XLEN-1:0]    data,
    input  logic [SHAMT_W-1:0] k,
    input  logic [2:0]         op,
    input  logic               sign,
    output logic [XLEN-1:0]    result
);
    logic [SHAMT_W:0] d;
    logic [SHAMT_W:0] dc;
    logic [XLEN-1:0]  fill;
    assign d = (SHAMT_W+1)'(1) << k;
    // complementary distance for the wrap-around half of a rotate
    assign dc = (SHAMT_W+1)'(XLEN) - d;
    assign fill = sign ? ~({XLEN{1'b1}} >> d) : '0;
    assign result = op == OP_SLL ? data << d :
                    op == OP_SRL ? data >> d :
                    op == OP_SRA ? (data >> d) | fill :
                    op == OP_ROL ? (data << d) | (data >> dc) :
                    op == OP_ROR ? (data >> d) | (data << dc) : '0;
endmodule

// File: rtl/shift_seq_unit.sv
// shift_seq_unit: iterative shift/rotate, one shift-amount bit per cycle, fixed latency
//   i_clk   : clock, rising edge
//   i_reset : asynchronous active-high reset
//   bus     : request/result handshake (slave side of shift_seq_unit_if)
module shift_seq_unit import shift_seq_unit_pkg::*; #(
    parameter int XLEN = DEF_XLEN,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input logic i_clk,
    input logic i_reset,
    shift_seq_unit_if.slave bus
);
    shift_state_e       state;
    shift_state_e       state_nx;
    logic [XLEN-1:0]    acc;
    logic [XLEN-1:0]    acc_nx;
    logic [XLEN-1:0]    stage_out;
    logic [XLEN-1:0]    data;
    logic [SHAMT_W-1:0] shamt;
    logic [SHAMT_W-1:0] cnt;
    logic [2:0]         op;
    logic               sign;
    logic               accept;
    logic               last;
    assign accept = bus.i_valid && state == S_IDLE && !bus.i_kill;
    assign last = cnt == SHAMT_W'(SHAMT_W - 1);
    shift_stage #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_stage (
        .data(acc),
        .k(cnt),
        .op(op),
        .sign(sign),
        .result(stage_out)
    );
    // each stage applies only when its shift-amount bit is set
    assign acc_nx = shamt[cnt] ? stage_out : acc;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= S_IDLE;
        else state <= state_nx;
    end
    // kill overrides everything, including a same-cycle accept or result handoff
    always_comb begin
        state_nx = bus.i_kill ? S_IDLE :
                   state == S_IDLE ? (bus.i_valid ? S_BUSY : S_IDLE) :
                   state == S_BUSY ? (last ? S_DONE : S_BUSY) :
                   (bus.i_ready ? S_IDLE : S_DONE);
    end
    always_comb begin
        bus.o_ready = state == S_IDLE;
        bus.o_valid = state == S_DONE;
        bus.o_data = data;
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            acc <= '0;
            shamt <= '0;
            cnt <= '0;
            op <= '0;
            sign <= 1'b0;
            data <= '0;
        end else if (accept) begin
            acc <= bus.i_a;
            shamt <= bus.i_b[SHAMT_W-1:0];
            op <= bus.i_op;
            sign <= bus.i_a[XLEN-1];
            cnt <= '0;
        end else if (state == S_BUSY && !bus.i_kill) begin
            acc <= acc_nx;
            cnt <= cnt + 1'b1;
            if (last) data <= op_known(op) ? acc_nx : '0;
        end
    end
endmodule

// File: tb/tb_shift_seq_unit.sv
// tb_shift_seq_unit: scoreboard bench for shift_seq_unit
module tb_shift_seq_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    logic [31:0] sb[$];
    shift_seq_unit_if bus ();
    shift_seq_unit dut (.i_clk(clk), .i_reset(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        int s;
        s = int'(b[4:0]);
        case (op)
            3'd0: return a << s;
            3'd1: return a >> s;
            3'd2: return 32'($signed(a) >>> s);
            3'd3: return s == 0 ? a : (a << s) | (a >> (32 - s));
            3'd4: return s == 0 ? a : (a >> s) | (a << (32 - s));
            default: return 32'h0;
        endcase
    endfunction

    task automatic accept_only(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.o_ready) break;
        end
        chk("ready_wait", 32'(bus.o_ready), 32'd1);
        bus.i_valid = 1'b1;
        bus.i_op = op;
        bus.i_a = a;
        bus.i_b = b;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_op = 3'($urandom_range(0, 7));
        bus.i_a = $urandom;
        bus.i_b = $urandom;
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
        int n;
        logic [31:0] exp;
        sb.push_back(model(op, a, b));
        accept_only(op, a, b);
        for (n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (bus.o_valid) break;
        end
        chk({tag, "_lat"}, 32'(n), 32'd5);
        exp = sb.pop_front();
        chk(tag, bus.o_data, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_v"}, 32'(bus.o_valid), 32'd1);
            chk({tag, "_hold_r"}, 32'(bus.o_ready), 32'd0);
            chk({tag, "_hold_d"}, bus.o_data, exp);
        end
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        chk({tag, "_post_v"}, 32'(bus.o_valid), 32'd0);
        chk({tag, "_post_r"}, 32'(bus.o_ready), 32'd1);
    endtask

    task automatic no_valid(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_valid) seen++;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.i_op = 3'd0;
        bus.i_a = '0;
        bus.i_b = '0;
        bus.i_kill = 1'b0;
        bus.i_ready = 1'b0;
        #2;
        chk("rst_ready", 32'(bus.o_ready), 32'd1);
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_data", bus.o_data, 32'h0);
        #10 rst = 1'b0;
        run("sll31", 3'd0, 32'h0000_0001, 32'd31, 0);
        chk("sll31_ref", model(3'd0, 32'h0000_0001, 32'd31), 32'h8000_0000);
        run("sra_neg", 3'd2, 32'h8000_0000, 32'd4, 0);
        chk("sra_neg_ref", model(3'd2, 32'h8000_0000, 32'd4), 32'hF800_0000);
        run("sra_pos", 3'd2, 32'h7000_0000, 32'd4, 0);
        run("ror4", 3'd4, 32'h0000_00F1, 32'd4, 0);
        chk("ror4_ref", model(3'd4, 32'h0000_00F1, 32'd4), 32'h1000_000F);
        run("rol1", 3'd3, 32'h8000_0001, 32'd1, 0);
        run("b_hi_ign", 3'd0, 32'h0000_0001, 32'h25, 0);
        chk("b_hi_ref", model(3'd0, 32'h0000_0001, 32'h25), 32'h0000_0020);
        run("sra_zero", 3'd2, 32'h8765_4321, 32'd0, 0);
        run("rol_zero", 3'd3, 32'hDEAD_BEEF, 32'd0, 0);
        run("invalid", 3'd7, 32'hFFFF_FFFF, 32'd3, 0);
        run("srl31", 3'd1, 32'hFFFF_FFFF, 32'd31, 0);
        run("bp", 3'd4, 32'h1234_5678, 32'd12, 10);
        for (int i = 0; i < 20; i++)
            run("rnd", 3'($urandom_range(0, 5)), $urandom, $urandom, i % 3);
        // kill during the third busy cycle
        accept_only(3'd0, 32'hABCD_0123, 32'd7);
        @(posedge clk);
        @(posedge clk);
        #1 bus.i_kill = 1'b1;
        @(posedge clk);
        #1 bus.i_kill = 1'b0;
        chk("kill_ready", 32'(bus.o_ready), 32'd1);
        chk("kill_valid", 32'(bus.o_valid), 32'd0);
        no_valid("kill_novalid", 10);
        run("srl8", 3'd1, 32'hFFFF_FFFF, 32'd8, 0);
        chk("srl8_ref", model(3'd1, 32'hFFFF_FFFF, 32'd8), 32'h00FF_FFFF);
        // kill beats a same-cycle accept
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_kill = 1'b1;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_kill = 1'b0;
        chk("kb_ready", 32'(bus.o_ready), 32'd1);
        no_valid("kb_novalid", 8);
        // kill in DONE with i_ready high discards the result
        accept_only(3'd0, 32'h1, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("kd_valid", 32'(bus.o_valid), 32'd1);
        bus.i_kill = 1'b1;
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_kill = 1'b0;
        bus.i_ready = 1'b0;
        chk("kd_ready", 32'(bus.o_ready), 32'd1);
        chk("kd_valid2", 32'(bus.o_valid), 32'd0);
        // asynchronous reset between edges mid-operation
        accept_only(3'd3, 32'h0F0F_0F0F, 32'd9);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.o_valid), 32'd0);
        chk("arst_ready", 32'(bus.o_ready), 32'd1);
        chk("arst_data", bus.o_data, 32'h0);
        #2 rst = 1'b0;
        no_valid("arst_novalid", 8);
        run("after_rst", 3'd2, 32'hC000_0000, 32'd30, 0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
